// File: rtl/opc5_uart.sv
// OPC5 memory-mapped UART: 4-word register window (DATA, STATUS, BAUD, reserved),
// 4-entry transmit FIFO, single-byte receive holding register, 8N1 framing.
//
// Bus protocol: a cycle is a read when sel & rnw, a write when sel & !rnw.
// Reads return data combinationally in the same cycle. Any side effect of a
// cycle (DATA pop, FIFO push, register load) lands on the rising edge that
// ends that cycle. There is no back-pressure: a DATA write while the FIFO is
// full is silently dropped.
module opc5_uart #(
    parameter logic [15:0] BASE_ADDR = 16'hFE00,
    parameter logic [15:0] DIV_RESET = 16'd433
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic [15:0] address,
    input  logic        rnw,
    input  logic [15:0] din,
    output logic [15:0] dout,
    output logic        data_oe,
    output logic        txd,
    input  logic        rxd
);

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_BAUD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [1:0] offset;
    logic       rx_pop;
    logic       tx_push;
    logic       baud_wr;
    logic       status_wr;

    logic [15:0] baud;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;
    logic        tx_idle;
    logic        tx_full;
    logic [15:0] rd_data;

    assign sel       = (address[15:2] == BASE_ADDR[15:2]);
    assign offset    = address[1:0];
    assign data_oe   = sel & rnw;
    assign rx_pop    = sel & rnw & (offset == OFF_DATA);
    assign tx_push   = sel & ~rnw & (offset == OFF_DATA) & ~tx_full;
    assign baud_wr   = sel & ~rnw & (offset == OFF_BAUD);
    assign status_wr = sel & ~rnw & (offset == OFF_STATUS);

    // Read mux; reserved offset and unselected cycles return zero
    always_comb begin
        rd_data = 16'h0000;
        case (offset)
            OFF_DATA:   rd_data = {8'h00, rx_byte};
            OFF_STATUS: rd_data = {11'h000, frame_err, overrun, rx_valid, tx_idle, tx_full};
            OFF_BAUD:   rd_data = baud;
            default:    rd_data = 16'h0000;
        endcase
        dout = data_oe ? rd_data : 16'h0000;
    end

    // Baud divisor register; counters pick up a new value only at their next reload
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            baud <= DIV_RESET;
        end else if (baud_wr) begin
            baud <= din;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_empty;
    logic        tx_load;

    uart_state_t tx_state;
    logic [15:0] tx_cnt;
    logic [7:0]  tx_shift;
    logic [2:0]  tx_idx;

    assign fifo_empty = (fifo_count == 3'd0);
    assign tx_full    = (fifo_count == 3'd4);
    assign tx_idle    = fifo_empty & (tx_state == S_IDLE);
    // The shifter takes the FIFO head from IDLE, or straight out of STOP for back-to-back frames
    assign tx_load    = ~fifo_empty & ((tx_state == S_IDLE) |
                                       ((tx_state == S_STOP) & (tx_cnt == 16'd0)));

    // FIFO storage write port
    always_ff @(posedge clk) begin
        if (tx_push) begin
            fifo_mem[wr_ptr] <= din[7:0];
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 2'd1;
            if (tx_load) rd_ptr <= rd_ptr + 2'd1;
            case ({tx_push, tx_load})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmit FSM: each non-idle state holds txd for baud+1 clocks
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_shift <= 8'h00;
            tx_idx   <= 3'd0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (tx_load) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= baud;
                        txd      <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_idx   <= 3'd0;
                        tx_cnt   <= baud;
                        tx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else begin
                        tx_cnt <= baud;
                        if (tx_idx == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (tx_cnt != 16'd0) begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end else if (tx_load) begin
                        tx_shift <= fifo_mem[rd_ptr];
                        tx_cnt   <= baud;
                        txd      <= 1'b0;
                        tx_state <= S_START;
                    end else begin
                        tx_state <= S_IDLE;
                    end
                end
                default: begin
                    tx_state <= S_IDLE;
                    txd      <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]  rx_sync;
    logic        rx_s;
    logic        rx_prev;
    logic [15:0] rx_half;
    logic [15:0] rx_half_m1;

    uart_state_t rx_state;
    logic [15:0] rx_cnt;
    logic [7:0]  rx_shift;
    logic [2:0]  rx_idx;

    assign rx_s       = rx_sync[1];
    // (baud+1)/2 without a 17-bit intermediate
    assign rx_half    = (baud >> 1) + {15'd0, baud[0]};
    // Countdown that lands the START sample rx_half clocks after the edge (minimum one)
    assign rx_half_m1 = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

    // Two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rxd};
            rx_prev <= rx_sync[1];
        end
    end

    // Receive FSM and status flags; a completing frame takes priority over a same-cycle pop
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rx_state  <= S_IDLE;
            rx_cnt    <= 16'd0;
            rx_shift  <= 8'h00;
            rx_idx    <= 3'd0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_pop) rx_valid <= 1'b0;
            if (status_wr && din[3]) overrun <= 1'b0;
            if (status_wr && din[4]) frame_err <= 1'b0;

            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_cnt   <= rx_half_m1;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else if (rx_s) begin
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt   <= baud;
                        rx_idx   <= 3'd0;
                        rx_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_cnt   <= baud;
                        if (rx_idx == 3'd7) begin
                            rx_state <= S_STOP;
                        end else begin
                            rx_idx <= rx_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (rx_cnt != 16'd0) begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end else begin
                        rx_state <= S_IDLE;
                        if (rx_s) begin
                            if (rx_valid && !rx_pop) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_byte  <= rx_shift;
                                rx_valid <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opc5_uart.sv
// Directed testbench for opc5_uart: register access, TX framing and FIFO,
// RX reception with overrun/framing errors, and reset during a frame.
module tb_opc5_uart;

  localparam logic [15:0] A_DATA   = 16'hFE00;
  localparam logic [15:0] A_STATUS = 16'hFE01;
  localparam logic [15:0] A_BAUD   = 16'hFE02;
  localparam logic [15:0] A_RSVD   = 16'hFE03;
  localparam logic [15:0] A_OTHER  = 16'hFE04;
  localparam logic [15:0] A_IDLE   = 16'h0000;

  logic        clk;
  logic        reset_b;
  logic [15:0] address;
  logic        rnw;
  logic [15:0] din;
  logic [15:0] dout;
  logic        data_oe;
  logic        txd;
  logic        rxd;

  int n_tests = 0;
  int n_fail  = 0;

  logic rec = 1'b0;
  logic txd_log[$];

  opc5_uart #(
    .BASE_ADDR(16'hFE00),
    .DIV_RESET(16'd433)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .address(address),
    .rnw(rnw),
    .din(din),
    .dout(dout),
    .data_oe(data_oe),
    .txd(txd),
    .rxd(rxd)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // txd recorder for the back-to-back frame test
  always @(negedge clk) begin
    if (rec) txd_log.push_back(txd);
  end

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a;
    rnw     = 1'b0;
    din     = d;
    @(negedge clk);
    address = A_IDLE;
    rnw     = 1'b1;
    din     = 16'h0000;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a;
    rnw     = 1'b1;
    #1;
    d = dout;
    @(posedge clk);
    #1;
    address = A_IDLE;
  endtask

  task automatic check_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  // Drive one 8N1 frame at 8 clocks per bit (BAUD=7), then idle high
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (8) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  initial begin
    logic [9:0]  exp_a5;
    logic [3:0]  got4;
    logic [9:0]  got10;
    logic [7:0]  burst [6];
    int          first;
    int          zeros;
    int          idx;

    burst[0] = 8'h5A; burst[1] = 8'h01; burst[2] = 8'hFF;
    burst[3] = 8'h80; burst[4] = 8'h3C; burst[5] = 8'hEE;

    reset_b = 1'b0;
    address = A_IDLE;
    rnw     = 1'b1;
    din     = 16'h0000;
    rxd     = 1'b1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_txd", {15'h0, txd}, 16'h0001);
    check("rst_oe_unsel", {15'h0, data_oe}, 16'h0000);
    address = A_STATUS;
    #1;
    check("rst_status_in_reset", dout, 16'h0002);
    check("rst_oe_in_reset", {15'h0, data_oe}, 16'h0001);
    @(negedge clk);
    address = A_IDLE;
    reset_b = 1'b1;

    check_read("rst_baud", A_BAUD, 16'h01B1);
    check_read("rst_data", A_DATA, 16'h0000);
    check_read("rsvd_read", A_RSVD, 16'h0000);
    bus_write(A_RSVD, 16'hFFFF);
    check_read("rsvd_write_status", A_STATUS, 16'h0002);
    check_read("rsvd_write_baud", A_BAUD, 16'h01B1);
    bus_write(A_OTHER, 16'h00AA);
    check_read("unsel_write_status", A_STATUS, 16'h0002);
    @(negedge clk);
    address = A_OTHER;
    #1;
    check("unsel_read_oe", {15'h0, data_oe}, 16'h0000);
    check("unsel_read_dout", dout, 16'h0000);
    address = A_IDLE;

    // ---- single TX frame, BAUD=3 ----
    bus_write(A_BAUD, 16'h0003);
    check_read("baud_rw", A_BAUD, 16'h0003);
    exp_a5 = 10'b1_10100101_0;
    bus_write(A_DATA, 16'h00A5);
    @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      for (int k = 0; k < 4; k++) begin
        got4[k] = txd;
        @(negedge clk);
      end
      check($sformatf("tx_a5_slot%0d", s), {12'h0, got4}, {12'h0, {4{exp_a5[s]}}});
    end
    check_read("tx_idle_after", A_STATUS, 16'h0002);

    // ---- back-to-back writes: 1 shifted, 4 queued, 6th dropped ----
    rec = 1'b1;
    @(negedge clk);
    address = A_DATA;
    rnw     = 1'b0;
    din     = {8'h00, burst[0]};
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      din = {8'h00, burst[i]};
    end
    @(negedge clk);
    address = A_STATUS;
    rnw     = 1'b1;
    din     = 16'h0000;
    #1;
    check("burst_full_status", dout, 16'h0001);
    address = A_IDLE;
    repeat (300) @(negedge clk);
    rec = 1'b0;

    first = -1;
    for (int i = 0; i < txd_log.size(); i++) begin
      if (first < 0 && txd_log[i] == 1'b0) first = i;
    end
    check("burst_start_found", {15'h0, first >= 0}, 16'h0001);
    if (first >= 0) begin
      for (int f = 0; f < 5; f++) begin
        for (int s = 0; s < 10; s++) begin
          idx = first + f * 40 + s * 4 + 2;
          got10[s] = (idx < txd_log.size()) ? txd_log[idx] : 1'bx;
        end
        check($sformatf("burst_frame%0d", f), {6'h0, got10}, {6'h0, 1'b1, burst[f], 1'b0});
      end
      zeros = 0;
      for (int i = first + 200; i < first + 240; i++) begin
        if (i >= txd_log.size() || txd_log[i] !== 1'b1) zeros++;
      end
      check("burst_no_sixth", zeros[15:0], 16'h0000);
    end
    check_read("burst_idle_after", A_STATUS, 16'h0002);

    // ---- RX, BAUD=7 ----
    bus_write(A_BAUD, 16'h0007);
    rx_send(8'h3C, 1'b1);
    check_read("rx_valid_set", A_STATUS, 16'h0006);
    check_read("rx_data_3c", A_DATA, 16'h003C);
    check_read("rx_valid_popped", A_STATUS, 16'h0002);

    // ---- overrun ----
    rx_send(8'hA1, 1'b1);
    rx_send(8'h5E, 1'b1);
    check_read("ovr_status", A_STATUS, 16'h000E);
    check_read("ovr_data_first", A_DATA, 16'h00A1);
    check_read("ovr_after_pop", A_STATUS, 16'h000A);
    bus_write(A_STATUS, 16'h0008);
    check_read("ovr_cleared", A_STATUS, 16'h0002);

    // ---- framing error ----
    rx_send(8'h77, 1'b1);
    rx_send(8'h12, 1'b0);
    check_read("ferr_status", A_STATUS, 16'h0016);
    check_read("ferr_data_kept", A_DATA, 16'h0077);
    check_read("ferr_after_pop", A_STATUS, 16'h0012);
    bus_write(A_STATUS, 16'h0010);
    check_read("ferr_cleared", A_STATUS, 16'h0002);

    // ---- 1-clock glitch ----
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_read("glitch_status", A_STATUS, 16'h0002);
    rx_send(8'h81, 1'b1);
    check_read("glitch_then_rx", A_DATA, 16'h0081);

    // ---- reset during a TX start bit ----
    bus_write(A_DATA, 16'h0055);
    repeat (3) @(negedge clk);
    check("rst_mid_pre_low", {15'h0, txd}, 16'h0000);
    reset_b = 1'b0;
    @(negedge clk);
    check("rst_mid_txd", {15'h0, txd}, 16'h0001);
    reset_b = 1'b1;
    check_read("rst_mid_status", A_STATUS, 16'h0002);
    check_read("rst_mid_baud", A_BAUD, 16'h01B1);
    zeros = 0;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1) zeros++;
    end
    check("rst_mid_quiet", zeros[15:0], 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
